// File: rtl/data_memory_lsu_if.sv
// Load/store bus between the datapath (ALU address, register-file store data)
// and the data memory LSU.
interface data_memory_lsu_if #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 32
);
    logic              mem_write;
    logic              mem_read;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   write_data;
    logic [XLEN-1:0]   read_data;
    logic              busy;
    logic              fault;
    logic [7:0]        fault_count;

    modport master (
        output mem_write, mem_read, addr, funct3, write_data,
        input  read_data, busy, fault, fault_count
    );

    modport slave (
        input  mem_write, mem_read, addr, funct3, write_data,
        output read_data, busy, fault, fault_count
    );
endinterface

// File: rtl/data_memory_lsu.sv
// Data memory with RV32/RV64 load/store sizes, byte-lane writes, load
// extension, fault detection, a saturating fault counter and a post-reset
// sequential clear of the whole array.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   CLEAR | writing zero to mem[clear_idx], one word per cycle; busy=1
//   READY | servicing loads and stores
module data_memory_lsu #(
    parameter int XLEN   = 64,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    data_memory_lsu_if.slave    bus
);
    localparam int BYTES = XLEN / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  clear_idx_q, clear_idx_d;
    logic [7:0]        fault_count_q, fault_count_d;
    logic [XLEN-1:0]   mem_q [DEPTH];

    logic [OFF_W-1:0]  off;
    logic [IDX_W-1:0]  widx;
    logic [1:0]        size;
    logic [OFF_W-1:0]  align_mask;
    logic [BYTES-1:0]  size_lanes;
    logic [BYTES-1:0]  lane_en;
    logic [XLEN-1:0]   wdata_sh;
    logic [XLEN-1:0]   rd_shifted;
    logic [XLEN-1:0]   rd_ext;
    logic              req, misaligned, out_of_range, illegal, fault, do_store;

    // Address/size decode and fault qualification
    always_comb begin
        off          = bus.addr[OFF_W-1:0];
        widx         = bus.addr[OFF_W+IDX_W-1:OFF_W];
        size         = bus.funct3[1:0];
        align_mask   = OFF_W'((1 << size) - 1);
        misaligned   = |(off & align_mask);
        out_of_range = |(bus.addr >> (OFF_W + IDX_W));
        illegal      = (bus.funct3 == 3'b111)
                     || ((XLEN == 32) && ((bus.funct3 == 3'b011) || (bus.funct3 == 3'b110)))
                     || (bus.mem_write && bus.funct3[2]);
        req          = bus.mem_read || bus.mem_write;
        fault        = (state_q == READY) && req && (misaligned || out_of_range || illegal);
        do_store     = (state_q == READY) && bus.mem_write && !fault;
        case (size)
            2'd0:    size_lanes = BYTES'(1);
            2'd1:    size_lanes = BYTES'(3);
            2'd2:    size_lanes = BYTES'(15);
            default: size_lanes = '1;
        endcase
        lane_en  = size_lanes << off;
        wdata_sh = bus.write_data << {off, 3'b000};
    end

    // Load path: lane select, then sign or zero extension; the array read is
    // combinational so a same-cycle store still returns the old contents
    always_comb begin
        rd_shifted = mem_q[widx] >> {off, 3'b000};
        case (size)
            2'd0:    rd_ext = bus.funct3[2] ? XLEN'(rd_shifted[7:0])
                                            : XLEN'($signed(rd_shifted[7:0]));
            2'd1:    rd_ext = bus.funct3[2] ? XLEN'(rd_shifted[15:0])
                                            : XLEN'($signed(rd_shifted[15:0]));
            2'd2:    rd_ext = bus.funct3[2] ? XLEN'(rd_shifted[31:0])
                                            : XLEN'($signed(rd_shifted[31:0]));
            default: rd_ext = rd_shifted;
        endcase
        bus.read_data = ((state_q == READY) && bus.mem_read && !fault) ? rd_ext : '0;
    end

    // Next-state logic for the clear sequencer and fault counter
    always_comb begin
        state_d       = state_q;
        clear_idx_d   = clear_idx_q;
        fault_count_d = fault_count_q;
        case (state_q)
            CLEAR: begin
                clear_idx_d = clear_idx_q + IDX_W'(1);
                if (clear_idx_q == IDX_W'(DEPTH - 1)) begin
                    state_d = READY;
                end
            end
            default: begin
                if (fault && (fault_count_q != 8'hFF)) begin
                    fault_count_d = fault_count_q + 8'd1;
                end
            end
        endcase
    end

    // State, clear index and fault counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= CLEAR;
            clear_idx_q   <= '0;
            fault_count_q <= '0;
        end else begin
            state_q       <= state_d;
            clear_idx_q   <= clear_idx_d;
            fault_count_q <= fault_count_d;
        end
    end

    // Array writes: zero fill while clearing, byte-lane store when ready
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == CLEAR) begin
                mem_q[clear_idx_q] <= '0;
            end else if (do_store) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (lane_en[b]) begin
                        mem_q[widx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
                    end
                end
            end
        end
    end

    assign bus.busy        = (state_q == CLEAR);
    assign bus.fault       = fault;
    assign bus.fault_count = fault_count_q;
endmodule

// File: tb/tb_data_memory_lsu.sv
module tb_data_memory_lsu;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    data_memory_lsu_if #(.XLEN(64), .ADDR_W(32)) bus ();
    data_memory_lsu_if #(.XLEN(32), .ADDR_W(32)) bus32 ();

    data_memory_lsu #(.XLEN(64), .DEPTH(128), .ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    data_memory_lsu #(.XLEN(32), .DEPTH(16), .ADDR_W(32)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic w, input logic [31:0] a,
                         input logic [2:0] f, input logic [63:0] d);
        bus.mem_read   = r;
        bus.mem_write  = w;
        bus.addr       = a;
        bus.funct3     = f;
        bus.write_data = d;
        #1;
    endtask

    task automatic drive32(input logic r, input logic w, input logic [31:0] a,
                           input logic [2:0] f, input logic [31:0] d);
        bus32.mem_read   = r;
        bus32.mem_write  = w;
        bus32.addr       = a;
        bus32.funct3     = f;
        bus32.write_data = d;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 3'b000, 64'h0);
        drive32(1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic store(input logic [31:0] a, input logic [2:0] f, input logic [63:0] d);
        drive(1'b0, 1'b1, a, f, d);
        tick();
    endtask

    task automatic test_reset();
        int cnt;
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy_high got %0b want 1", bus.busy);
        end
        drive(1'b1, 1'b0, 32'h0, 3'b111, 64'h0);
        checks++;
        if (bus.fault !== 1'b0 || bus.read_data !== 64'h0) begin
            errors++;
            $display("FAIL busy_quiet got fault=%0b rd=%h want 0/0", bus.fault, bus.read_data);
        end
        idle();
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 300) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        checks++;
        if (cnt != 128) begin
            errors++;
            $display("FAIL clear_length got %0d want 128", cnt);
        end
        checks++;
        if (bus.fault_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_fault_count got %0d want 0", bus.fault_count);
        end
        for (int a = 0; a <= 32'h3F8; a += 8) begin
            drive(1'b1, 1'b0, a, 3'b011, 64'h0);
            checks++;
            if (bus.read_data !== 64'h0 || bus.fault !== 1'b0) begin
                errors++;
                $display("FAIL cleared_ld @%h got %h fault=%0b want 0", a, bus.read_data, bus.fault);
            end
        end
        idle();
    endtask

    task automatic test_byte_lanes();
        store(32'h10, 3'b011, 64'h1122334455667788);
        store(32'h13, 3'b000, 64'hFFFF_FFFF_FFFF_FFAB);
        drive(1'b1, 1'b0, 32'h10, 3'b011, 64'h0);
        checks++;
        if (bus.read_data !== 64'h11223344AB667788) begin
            errors++;
            $display("FAIL sb_lane got %h want 11223344ab667788", bus.read_data);
        end
        idle();
        store(32'h16, 3'b001, 64'h0000_0000_1234_BEEF);
        drive(1'b1, 1'b0, 32'h10, 3'b011, 64'h0);
        checks++;
        if (bus.read_data !== 64'hBEEF3344AB667788) begin
            errors++;
            $display("FAIL sh_lane got %h want beef3344ab667788", bus.read_data);
        end
        drive(1'b1, 1'b0, 32'h13, 3'b100, 64'h0);
        checks++;
        if (bus.read_data !== 64'h00000000000000AB) begin
            errors++;
            $display("FAIL lbu_13 got %h want ab", bus.read_data);
        end
        drive(1'b1, 1'b0, 32'h16, 3'b001, 64'h0);
        checks++;
        if (bus.read_data !== 64'hFFFFFFFFFFFFBEEF) begin
            errors++;
            $display("FAIL lh_16 got %h want ffffffffffffbeef", bus.read_data);
        end
        idle();
    endtask

    task automatic test_extension();
        store(32'h20, 3'b010, 64'h0000_0000_8000_0001);
        drive(1'b1, 1'b0, 32'h20, 3'b010, 64'h0);
        checks++;
        if (bus.read_data !== 64'hFFFFFFFF80000001) begin
            errors++;
            $display("FAIL lw_sign got %h want ffffffff80000001", bus.read_data);
        end
        drive(1'b1, 1'b0, 32'h20, 3'b110, 64'h0);
        checks++;
        if (bus.read_data !== 64'h0000000080000001) begin
            errors++;
            $display("FAIL lwu got %h want 0000000080000001", bus.read_data);
        end
        drive(1'b1, 1'b0, 32'h20, 3'b000, 64'h0);
        checks++;
        if (bus.read_data !== 64'h1) begin
            errors++;
            $display("FAIL lb_20 got %h want 1", bus.read_data);
        end
        drive(1'b1, 1'b0, 32'h23, 3'b100, 64'h0);
        checks++;
        if (bus.read_data !== 64'h80) begin
            errors++;
            $display("FAIL lbu_23 got %h want 80", bus.read_data);
        end
        drive(1'b1, 1'b0, 32'h23, 3'b000, 64'h0);
        checks++;
        if (bus.read_data !== 64'hFFFFFFFFFFFFFF80) begin
            errors++;
            $display("FAIL lb_23 got %h want ffffffffffffff80", bus.read_data);
        end
        drive(1'b1, 1'b0, 32'h22, 3'b101, 64'h0);
        checks++;
        if (bus.read_data !== 64'h8000) begin
            errors++;
            $display("FAIL lhu_22 got %h want 8000", bus.read_data);
        end
        idle();
    endtask

    task automatic test_faults();
        drive(1'b1, 1'b0, 32'h21, 3'b001, 64'h0);
        checks++;
        if (bus.fault !== 1'b1 || bus.read_data !== 64'h0) begin
            errors++;
            $display("FAIL lh_misaligned got fault=%0b rd=%h want 1/0", bus.fault, bus.read_data);
        end
        tick();
        drive(1'b0, 1'b1, 32'h22, 3'b010, 64'h12345678);
        checks++;
        if (bus.fault !== 1'b1) begin
            errors++;
            $display("FAIL sw_misaligned got fault=%0b want 1", bus.fault);
        end
        tick();
        drive(1'b1, 1'b0, 32'h20, 3'b011, 64'h0);
        checks++;
        if (bus.read_data !== 64'h0000000080000001) begin
            errors++;
            $display("FAIL faulting_store_wrote got %h want 0000000080000001", bus.read_data);
        end
        drive(1'b1, 1'b0, 32'h400, 3'b011, 64'h0);
        checks++;
        if (bus.fault !== 1'b1 || bus.read_data !== 64'h0) begin
            errors++;
            $display("FAIL ld_out_of_range got fault=%0b rd=%h want 1/0", bus.fault, bus.read_data);
        end
        tick();
        drive(1'b1, 1'b0, 32'h0, 3'b111, 64'h0);
        checks++;
        if (bus.fault !== 1'b1) begin
            errors++;
            $display("FAIL funct3_111 got fault=%0b want 1", bus.fault);
        end
        tick();
        checks++;
        if (bus.fault_count !== 8'd4) begin
            errors++;
            $display("FAIL fault_count_4 got %0d want 4", bus.fault_count);
        end
        drive(1'b0, 1'b1, 32'h0, 3'b100, 64'hFF);
        checks++;
        if (bus.fault !== 1'b1) begin
            errors++;
            $display("FAIL store_unsigned_illegal got fault=%0b want 1", bus.fault);
        end
        tick();
        drive(1'b1, 1'b0, 32'h0, 3'b011, 64'h0);
        checks++;
        if (bus.read_data !== 64'h0 || bus.fault !== 1'b0) begin
            errors++;
            $display("FAIL illegal_store_wrote got %h fault=%0b want 0/0", bus.read_data, bus.fault);
        end
        drive(1'b1, 1'b0, 32'h3F8, 3'b011, 64'h0);
        checks++;
        if (bus.fault !== 1'b0) begin
            errors++;
            $display("FAIL ld_top_word got fault=%0b want 0", bus.fault);
        end
        idle();
        checks++;
        if (bus.fault_count !== 8'd5) begin
            errors++;
            $display("FAIL fault_count_5 got %0d want 5", bus.fault_count);
        end
    endtask

    task automatic test_read_during_write();
        store(32'h30, 3'b011, 64'h5);
        drive(1'b1, 1'b1, 32'h30, 3'b011, 64'h9);
        checks++;
        if (bus.read_data !== 64'h5 || bus.fault !== 1'b0) begin
            errors++;
            $display("FAIL rdw_old got %h fault=%0b want 5/0", bus.read_data, bus.fault);
        end
        tick();
        drive(1'b1, 1'b0, 32'h30, 3'b011, 64'h0);
        checks++;
        if (bus.read_data !== 64'h9) begin
            errors++;
            $display("FAIL rdw_new got %h want 9", bus.read_data);
        end
        idle();
        drive(1'b1, 1'b1, 32'h31, 3'b011, 64'h7);
        tick();
        checks++;
        if (bus.fault_count !== 8'd6) begin
            errors++;
            $display("FAIL rw_pair_one_fault got %0d want 6", bus.fault_count);
        end
        drive(1'b1, 1'b0, 32'h30, 3'b011, 64'h0);
        checks++;
        if (bus.read_data !== 64'h9) begin
            errors++;
            $display("FAIL rw_fault_wrote got %h want 9", bus.read_data);
        end
        idle();
    endtask

    task automatic test_saturation();
        drive(1'b1, 1'b0, 32'h0, 3'b111, 64'h0);
        repeat (300) @(posedge clk);
        #1;
        idle();
        checks++;
        if (bus.fault_count !== 8'd255) begin
            errors++;
            $display("FAIL fault_count_sat got %0d want 255", bus.fault_count);
        end
    endtask

    task automatic test_mid_reset();
        int cnt;
        store(32'h40, 3'b011, 64'hDEAD);
        drive(1'b1, 1'b0, 32'h40, 3'b011, 64'h0);
        checks++;
        if (bus.read_data !== 64'hDEAD) begin
            errors++;
            $display("FAIL pre_reset_ld got %h want dead", bus.read_data);
        end
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.fault_count !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset got busy=%0b fc=%0d want 1/0", bus.busy, bus.fault_count);
        end
        store(32'h40, 3'b011, 64'hBEEF);
        drive(1'b1, 1'b0, 32'h0, 3'b111, 64'h0);
        checks++;
        if (bus.fault !== 1'b0) begin
            errors++;
            $display("FAIL busy_fault got %0b want 0", bus.fault);
        end
        tick();
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 300) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        checks++;
        if (cnt != 128) begin
            errors++;
            $display("FAIL restart_clear_length got %0d want 128", cnt);
        end
        checks++;
        if (bus.fault_count !== 8'd0) begin
            errors++;
            $display("FAIL busy_fault_count got %0d want 0", bus.fault_count);
        end
        drive(1'b1, 1'b0, 32'h40, 3'b011, 64'h0);
        checks++;
        if (bus.read_data !== 64'h0) begin
            errors++;
            $display("FAIL post_clear_ld40 got %h want 0", bus.read_data);
        end
        drive(1'b1, 1'b0, 32'h30, 3'b011, 64'h0);
        checks++;
        if (bus.read_data !== 64'h0) begin
            errors++;
            $display("FAIL post_clear_ld30 got %h want 0", bus.read_data);
        end
        idle();
    endtask

    task automatic test_xlen32();
        checks++;
        if (bus32.busy !== 1'b0) begin
            errors++;
            $display("FAIL x32_busy got %0b want 0", bus32.busy);
        end
        drive32(1'b1, 1'b0, 32'h0, 3'b011, 32'h0);
        checks++;
        if (bus32.fault !== 1'b1) begin
            errors++;
            $display("FAIL x32_ld_illegal got fault=%0b want 1", bus32.fault);
        end
        drive32(1'b1, 1'b0, 32'h0, 3'b110, 32'h0);
        checks++;
        if (bus32.fault !== 1'b1) begin
            errors++;
            $display("FAIL x32_lwu_illegal got fault=%0b want 1", bus32.fault);
        end
        drive32(1'b0, 1'b1, 32'h4, 3'b010, 32'h80000001);
        tick();
        drive32(1'b1, 1'b0, 32'h4, 3'b010, 32'h0);
        checks++;
        if (bus32.read_data !== 32'h80000001 || bus32.fault !== 1'b0) begin
            errors++;
            $display("FAIL x32_lw got %h fault=%0b want 80000001/0", bus32.read_data, bus32.fault);
        end
        drive32(1'b1, 1'b0, 32'h6, 3'b001, 32'h0);
        checks++;
        if (bus32.read_data !== 32'hFFFF8000) begin
            errors++;
            $display("FAIL x32_lh got %h want ffff8000", bus32.read_data);
        end
        drive32(1'b1, 1'b0, 32'h7, 3'b100, 32'h0);
        checks++;
        if (bus32.read_data !== 32'h80) begin
            errors++;
            $display("FAIL x32_lbu got %h want 80", bus32.read_data);
        end
        drive32(1'b1, 1'b0, 32'h40, 3'b010, 32'h0);
        checks++;
        if (bus32.fault !== 1'b1) begin
            errors++;
            $display("FAIL x32_out_of_range got fault=%0b want 1", bus32.fault);
        end
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle();
        test_reset();
        test_byte_lanes();
        test_extension();
        test_faults();
        test_read_during_write();
        test_saturation();
        test_mid_reset();
        test_xlen32();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_memory_lsu.md
Name: data_memory_lsu

Overview:
- Parametrised successor to the single-cycle core's data memory.
- Adds the following over a plain word array:
  - RV32/RV64 load/store sizes with byte-lane writes.
  - Sign and zero extension on loads.
  - Misalignment and out-of-range fault detection.
  - A saturating fault counter.
  - A post-reset sequential clear of the whole array.
- Sits between the ALU address output / register-file store data and the writeback mux.

Parameters:
XLEN, 64, data width in bits; legal values are 32 or 64.
DEPTH, 128, number of XLEN-wide words; must be a power of 2.
ADDR_W, 32, byte-address width; must satisfy ADDR_W >= log2(DEPTH*XLEN/8).

Ports:
clk  input  1  single clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
mem_write  input  1  store request this cycle.
mem_read  input  1  load request this cycle.
addr  input  ADDR_W  byte address, shared by load and store.
funct3  input  3  RISC-V size/sign field of the instruction.
write_data  input  XLEN  store data; the value sits in the low bits.
read_data  output  XLEN  extended load result; combinational in the READY state.
busy  output  1  high while the array is being cleared.
fault  output  1  combinational; current request is misaligned, out-of-range or has an illegal funct3.
fault_count  output  8  saturating count of faulting requests.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled at the rising edge.
- State machine: two states, CLEAR and READY.
  - reset=1 at an edge: next state CLEAR, clear_idx=0, fault_count=0.
  - CLEAR: each edge writes 0 to mem[clear_idx] and increments clear_idx. After the edge that writes index DEPTH-1, the state becomes READY.
  - The clear therefore takes exactly DEPTH cycles after reset deasserts.
  - busy=1 in CLEAR and 0 in READY. busy is a decode of the registered state.
- Reset during CLEAR restarts the clear from index 0.
- Reset in READY re-clears the whole array.
- While busy=1:
  - Stores are ignored.
  - read_data=0 and fault=0.
  - fault_count does not change.
- Address decode, with BYTES=XLEN/8:
  - Byte offset: off = addr[log2(BYTES)-1:0].
  - Word index: widx = addr[log2(BYTES)+log2(DEPTH)-1 : log2(BYTES)].
  - Out-of-range: any set bit in addr above the index field.
- Size decode:
  - 000 = byte, signed load / SB.
  - 001 = half, signed load / SH.
  - 010 = word, signed load / SW.
  - 011 = double (LD/SD).
  - 100 = LBU.
  - 101 = LHU.
  - 110 = LWU.
  - 111 = illegal.
  - 011 and 110 are illegal when XLEN=32.
  - A store with funct3[2]=1 is illegal.
- Alignment: an access of size N bytes is misaligned if off mod N != 0.
- fault is 1 when (mem_read or mem_write) and any of: misaligned, out-of-range, illegal funct3.
- Load, when mem_read=1, READY and fault=0:
  - Select N bytes of mem[widx] starting at byte off (little-endian).
  - Sign-extend for funct3[2]=0; zero-extend for funct3[2]=1.
  - Result appears in the same cycle.
  - read_data=0 when mem_read=0 or fault=1.
- Store, when mem_write=1, READY and fault=0:
  - At the rising edge, write write_data[8N-1:0] into bytes off..off+N-1 of mem[widx].
  - All other bytes keep their value.
- A faulting store writes nothing.
- mem_read and mem_write together:
  - Legal, using the same address and funct3.
  - read_data returns the pre-write contents; the store lands at the edge.
- fault_count:
  - Increments at the edge when fault=1 (READY only).
  - Saturates at 255.
  - A read+write pair counts as one fault.
- No read or write of X or uninitialised contents is ever observable after the clear completes.

Test Plan:
- Reset clear: hold reset 2 cycles, release, then probe busy.
  -> busy=1 for exactly 128 cycles, then 0. Any LD at addresses 0x0..0x3F8 -> 0.
- Byte lanes (XLEN=64):
  - SD 0x1122334455667788 @0x10, then SB 0xAB @0x13 -> LD @0x10 = 0x11223344AB667788.
  - SH 0xBEEF @0x16 -> LD = 0xBEEF3344AB667788.
- Sign and zero extension:
  - SW 0x80000001 @0x20 -> LW = 0xFFFFFFFF80000001, LWU = 0x0000000080000001.
  - LB @0x20 = 0x0000000000000001, LBU @0x23 = 0x80.
- Faults:
  - LH @0x21 -> fault=1, read_data=0.
  - SW @0x22 -> memory unchanged.
  - LD @0x400 (out of range) -> fault=1.
  - funct3=111 -> fault=1.
  - fault_count goes 0 -> 4; after 300 faults it holds at 255.
- Read-during-write: mem_read=mem_write=1, SD/LD @0x30, old value 0x5, new value 0x9.
  -> read_data=0x5 in that cycle; the next cycle's LD = 0x9.
- Mid-operation reset:
  - Store 0xDEAD @0x40, assert reset 1 cycle -> array re-cleared, fault_count=0.
  - Stores during busy are ignored; after clear, LD @0x40 = 0.
  - XLEN=32 build: funct3=011 -> fault=1.
